// File: rtl/edc_pkg.sv
// Shared definitions for the ECC-protected memory front-end.
// Contents:
//   ECC_BITS / HAM_BITS : check-bit counts for SEC-DED Hamming(39,32)
//   state_e             : controller FSM state encodings
//   HMASK               : data-bit masks for each Hamming parity bit
//   enc()               : 32-bit data -> 7 check bits
// Codeword layout: positions 1..38. Check bit c[k] sits at position 2^k.
// Data bits fill the remaining positions in ascending order, starting at 3.
// c[6] is even parity over the data and c[5:0].
package edc_pkg;

  localparam int DW       = 32;
  localparam int HAM_BITS = 6;
  localparam int ECC_BITS = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_CAP,
    ST_CHK,
    ST_RESP
  } state_e;

  function automatic logic [HAM_BITS-1:0][DW-1:0] gen_masks();
    logic [HAM_BITS-1:0][DW-1:0] m;
    int di;
    m  = '0;
    di = 0;
    for (int pos = 1; pos <= DW + HAM_BITS; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        for (int k = 0; k < HAM_BITS; k++) begin
          if (((pos >> k) & 1) != 0) m[k][di] = 1'b1;
        end
        di++;
      end
    end
    return m;
  endfunction

  localparam logic [HAM_BITS-1:0][DW-1:0] HMASK = gen_masks();

  function automatic logic [ECC_BITS-1:0] enc(input logic [DW-1:0] d);
    logic [ECC_BITS-1:0] c;
    c = '0;
    for (int k = 0; k < HAM_BITS; k++) c[k] = ^(d & HMASK[k]);
    c[ECC_BITS-1] = (^d) ^ (^c[HAM_BITS-1:0]);
    return c;
  endfunction

endpackage

// File: rtl/edc_encoder.sv
// Combinational SEC-DED check-bit generator (32 data bits -> 7 check bits).
// Ports:
//   data_i  : data word
//   check_o : {overall parity, Hamming c[5:0]}
module edc_encoder
  import edc_pkg::*;
(
  input  logic [DW-1:0]       data_i,
  output logic [ECC_BITS-1:0] check_o
);

  assign check_o = enc(data_i);

endmodule

// File: rtl/edc_mem_ctrl.sv
// Wishbone slave front-end for ECC-protected main memory.
// Full writes store data plus check bits in one cycle. Reads and partial writes
// fetch the word, pass it through the external corrector (edcc_mod) and then
// respond or merge and write back. Corrected and uncorrectable events are
// counted with saturating counters.
// Ports:
//   i_clk, i_rst                       : clock, synchronous active-high reset
//   i_wb_*, o_wb_dat/ack/err           : Wishbone slave
//   o_mem_en/we/adr, o_mem_dat_w,
//   o_ecc_dat_w, i_mem_dat_r,
//   i_ecc_dat_r                        : main + ECC memory port
//   o_edcc_main/ecc, i_edcc_dat/valid  : external corrector interface
//   o_ce_count, o_ue_count             : error counters
// Configuration macro: EDC_SCRUB_EN -- a read that hits a corrected error also
// writes the corrected word back to memory.
module edc_mem_ctrl
  import edc_pkg::*;
#(
  parameter int WB_DWIDTH  = 32,
  parameter int WB_SWIDTH  = 4,
  parameter int MEM_AWIDTH = 20,
  parameter int ECC_BITS   = 7,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_wb_adr,
  input  logic [WB_SWIDTH-1:0]  i_wb_sel,
  input  logic                  i_wb_we,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  input  logic [WB_DWIDTH-1:0]  i_wb_dat,
  output logic [WB_DWIDTH-1:0]  o_wb_dat,
  output logic                  o_wb_ack,
  output logic                  o_wb_err,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [MEM_AWIDTH-1:0] o_mem_adr,
  output logic [WB_DWIDTH-1:0]  o_mem_dat_w,
  output logic [WB_DWIDTH-1:0]  o_ecc_dat_w,
  input  logic [WB_DWIDTH-1:0]  i_mem_dat_r,
  input  logic [WB_DWIDTH-1:0]  i_ecc_dat_r,
  output logic [WB_DWIDTH-1:0]  o_edcc_main,
  output logic [WB_DWIDTH-1:0]  o_edcc_ecc,
  input  logic [WB_DWIDTH-1:0]  i_edcc_dat,
  input  logic                  i_edcc_valid,
  output logic [CNT_WIDTH-1:0]  o_ce_count,
  output logic [CNT_WIDTH-1:0]  o_ue_count
);

  state_e                 state_q;
  logic [WB_DWIDTH-1:0]   wdat_q;
  logic [WB_SWIDTH-1:0]   sel_q;
  logic                   we_q;
  logic [WB_DWIDTH-1:0]   wb_dat_q, mem_dat_w_q, ecc_dat_w_q, edcc_main_q, edcc_ecc_q;
  logic                   ack_q, err_q, mem_en_q, mem_we_q;
  logic [MEM_AWIDTH-1:0]  mem_adr_q;
  logic [CNT_WIDTH-1:0]   ce_q, ue_q;

  logic                   req, full_wr, ce_det;
  logic [WB_DWIDTH-1:0]   merged, enc_in;
  logic [ECC_BITS-1:0]    wr_chk, rd_chk;
  logic                   unused_adr;

  // Address bits outside the word-address field are ignored by design.
  assign unused_adr = ^{i_wb_adr[31:MEM_AWIDTH+2], i_wb_adr[1:0]};

  assign req     = i_wb_cyc & i_wb_stb & ~ack_q & ~err_q;
  assign full_wr = i_wb_we & (&i_wb_sel);

  // Partial write: selected bytes from the master over the corrected word.
  always_comb begin
    merged = i_edcc_dat;
    for (int b = 0; b < WB_SWIDTH; b++) begin
      if (sel_q[b]) merged[8*b +: 8] = wdat_q[8*b +: 8];
    end
  end

  // One encoder serves every write: master data on a full write, otherwise the
  // merged word (partial write) or the corrected word (scrub).
  assign enc_in = (state_q == ST_IDLE) ? i_wb_dat : (we_q ? merged : i_edcc_dat);

  edc_encoder u_enc_wr (.data_i(enc_in),      .check_o(wr_chk));
  edc_encoder u_enc_rd (.data_i(edcc_main_q), .check_o(rd_chk));

  // A correctable word whose stored check bits disagree with the raw data had
  // a single-bit error somewhere (data or check bits).
  assign ce_det = i_edcc_valid & (rd_chk != edcc_ecc_q[ECC_BITS-1:0]);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      wb_dat_q    <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_dat_w_q <= '0;
      ecc_dat_w_q <= '0;
      edcc_main_q <= '0;
      edcc_ecc_q  <= '0;
      ce_q        <= '0;
      ue_q        <= '0;
    end else begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            wdat_q    <= i_wb_dat;
            sel_q     <= i_wb_sel;
            we_q      <= i_wb_we;
            mem_adr_q <= i_wb_adr[MEM_AWIDTH+1:2];
            mem_en_q  <= 1'b1;
            if (full_wr) begin
              mem_we_q    <= 1'b1;
              mem_dat_w_q <= i_wb_dat;
              ecc_dat_w_q <= {{(WB_DWIDTH-ECC_BITS){1'b0}}, wr_chk};
              ack_q       <= 1'b1;
              state_q     <= ST_WR;
            end else begin
              state_q <= ST_RD;
            end
          end
        end
        ST_WR: state_q <= ST_IDLE;
        ST_RD: state_q <= ST_CAP;
        ST_CAP: begin
          edcc_main_q <= i_mem_dat_r;
          edcc_ecc_q  <= i_ecc_dat_r;
          state_q     <= ST_CHK;
        end
        // Response outputs are registered here so they appear in RESP.
        ST_CHK: begin
          state_q <= ST_RESP;
          if (!i_edcc_valid) begin
            err_q    <= 1'b1;
            wb_dat_q <= '0;
            ue_q     <= sat_inc(ue_q);
          end else begin
            if (ce_det) ce_q <= sat_inc(ce_q);
            ack_q <= 1'b1;
            if (we_q) begin
              mem_en_q    <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_dat_w_q <= merged;
              ecc_dat_w_q <= {{(WB_DWIDTH-ECC_BITS){1'b0}}, wr_chk};
            end else begin
              wb_dat_q <= i_edcc_dat;
`ifdef EDC_SCRUB_EN
              if (ce_det) begin
                mem_en_q    <= 1'b1;
                mem_we_q    <= 1'b1;
                mem_dat_w_q <= i_edcc_dat;
                ecc_dat_w_q <= {{(WB_DWIDTH-ECC_BITS){1'b0}}, wr_chk};
              end
`else
              // Without scrubbing the stored error stays in memory.
`endif
            end
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_wb_dat    = wb_dat_q;
  assign o_wb_ack    = ack_q;
  assign o_wb_err    = err_q;
  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_adr   = mem_adr_q;
  assign o_mem_dat_w = mem_dat_w_q;
  assign o_ecc_dat_w = ecc_dat_w_q;
  assign o_edcc_main = edcc_main_q;
  assign o_edcc_ecc  = edcc_ecc_q;
  assign o_ce_count  = ce_q;
  assign o_ue_count  = ue_q;

endmodule

// File: tb/tb_edc_mem_ctrl.sv
// Testbench for edc_mem_ctrl: memory model, behavioural SEC-DED corrector,
// directed vector table plus hand-written corner-case sequences.
module tb_edc_mem_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   wb_adr;
  logic [3:0]    wb_sel;
  logic          wb_we, wb_cyc, wb_stb;
  logic [31:0]   wb_dat_w;
  logic [31:0]   wb_dat_r;
  logic          wb_ack, wb_err;
  logic          mem_en, mem_we;
  logic [19:0]   mem_adr;
  logic [31:0]   mem_dat_w, ecc_dat_w, mem_dat_r, ecc_dat_r;
  logic [31:0]   edcc_main, edcc_ecc, edcc_dat;
  logic          edcc_valid;
  logic [CW-1:0] ce_cnt, ue_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;

  logic [31:0] mem [256];
  logic [31:0] ecc [256];

  always #5 clk = ~clk;

  edc_mem_ctrl #(.CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_adr(wb_adr), .i_wb_sel(wb_sel), .i_wb_we(wb_we),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_dat(wb_dat_w),
    .o_wb_dat(wb_dat_r), .o_wb_ack(wb_ack), .o_wb_err(wb_err),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_adr(mem_adr),
    .o_mem_dat_w(mem_dat_w), .o_ecc_dat_w(ecc_dat_w),
    .i_mem_dat_r(mem_dat_r), .i_ecc_dat_r(ecc_dat_r),
    .o_edcc_main(edcc_main), .o_edcc_ecc(edcc_ecc),
    .i_edcc_dat(edcc_dat), .i_edcc_valid(edcc_valid),
    .o_ce_count(ce_cnt), .o_ue_count(ue_cnt)
  );

  // Reference encoder built from codeword positions (syndrome form).
  function automatic logic [6:0] tb_enc(input logic [31:0] d);
    logic [38:0] cw;
    logic [6:0]  c;
    int di;
    cw = '0; c = '0; di = 0;
    for (int p = 1; p < 39; p++) begin
      if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16 && p != 32) begin
        cw[p] = d[di];
        di++;
      end
    end
    for (int p = 1; p < 39; p++) if (cw[p]) c[5:0] = c[5:0] ^ p[5:0];
    c[6] = ^{d, c[5:0]};
    return c;
  endfunction

  // Reference corrector: returns {valid, corrected data}.
  function automatic logic [32:0] tb_dec(input logic [31:0] d, input logic [6:0] e);
    logic [38:0] cw;
    logic [31:0] o;
    logic [5:0]  s;
    logic        par, ok;
    int di;
    cw = '0; di = 0; s = '0;
    cw[1] = e[0]; cw[2] = e[1]; cw[4] = e[2]; cw[8] = e[3]; cw[16] = e[4]; cw[32] = e[5];
    for (int p = 1; p < 39; p++) begin
      if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16 && p != 32) begin
        cw[p] = d[di];
        di++;
      end
    end
    for (int p = 1; p < 39; p++) if (cw[p]) s = s ^ p[5:0];
    par = ^{d, e};
    ok  = 1'b1;
    if (s != 0) begin
      if (par && s < 39) cw[s] = ~cw[s];
      else ok = 1'b0;
    end
    o = '0; di = 0;
    for (int p = 1; p < 39; p++) begin
      if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16 && p != 32) begin
        o[di] = cw[p];
        di++;
      end
    end
    return {ok, o};
  endfunction

  always_comb {edcc_valid, edcc_dat} = tb_dec(edcc_main, edcc_ecc[6:0]);

  // Memory model; accesses outside the modelled range return X.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_adr[7:0]] <= mem_dat_w;
        ecc[mem_adr[7:0]] <= ecc_dat_w;
        wr_cnt <= wr_cnt + 1;
      end
      mem_dat_r <= (mem_adr[19:8] == 0) ? mem[mem_adr[7:0]] : 32'hxxxx_xxxx;
      ecc_dat_r <= (mem_adr[19:8] == 0) ? ecc[mem_adr[7:0]] : 32'hxxxx_xxxx;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transfer: request held for one cycle only, then wait for ack/err.
  task automatic do_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat, output int lat, output logic got_err,
                        output logic [31:0] rdat);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_sel = sel; wb_adr = adr; wb_dat_w = dat;
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_dat_w = 32'h5A5A_5A5A;
    lat = -1; got_err = 1'b0; rdat = '0;
    for (int i = 1; i <= 10; i++) begin
      if (wb_ack || wb_err) begin
        lat = i; got_err = wb_err; rdat = wb_dat_r;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] exp_rdat;
    int          exp_lat;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t        vecs [12];
  int          lat;
  logic        gerr, seen;
  logic [31:0] rd;
  int          wr0;
  logic [31:0] exp_ce;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ecc[i] = '0; end
    vecs[0]  = '{1'b1, 4'hF, 32'h10,       32'hDEADBEEF, 32'h0,        1, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 4'hF, 32'h10,       32'h0,        32'hDEADBEEF, 4, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 4'hF, 32'hFFC00010, 32'h0,        32'hDEADBEEF, 4, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 4'hF, 32'h20,       32'h11223344, 32'h0,        1, 32'h11223344};
    vecs[4]  = '{1'b1, 4'h2, 32'h20,       32'h0000AB00, 32'h0,        4, 32'h1122AB44};
    vecs[5]  = '{1'b0, 4'h0, 32'h20,       32'h0,        32'h1122AB44, 4, 32'h1122AB44};
    vecs[6]  = '{1'b1, 4'h0, 32'h20,       32'hFFFFFFFF, 32'h0,        4, 32'h1122AB44};
    vecs[7]  = '{1'b1, 4'hF, 32'h34,       32'hFFFFFFFF, 32'h0,        1, 32'hFFFFFFFF};
    vecs[8]  = '{1'b1, 4'hC, 32'h34,       32'hA5A50000, 32'h0,        4, 32'hA5A5FFFF};
    vecs[9]  = '{1'b0, 4'hF, 32'h34,       32'h0,        32'hA5A5FFFF, 4, 32'hA5A5FFFF};
    vecs[10] = '{1'b1, 4'hF, 32'h3C,       32'h00000000, 32'h0,        1, 32'h00000000};
    vecs[11] = '{1'b1, 4'h1, 32'h3C,       32'h123456FF, 32'h0,        4, 32'h000000FF};

    rst = 1'b1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 0; wb_adr = 0; wb_dat_w = 0;
    repeat (3) @(negedge clk);
    chk("reset_ack_err", {30'b0, wb_ack, wb_err}, 32'h0);
    chk("reset_mem_en", {31'b0, mem_en}, 32'h0);
    chk("reset_counts", {ce_cnt, ue_cnt}, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_txn(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].wdat, lat, gerr, rd);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_err", i), {31'b0, gerr}, 32'h0);
      if (!vecs[i].we) chk($sformatf("v%0d_rdat", i), rd, vecs[i].exp_rdat);
      @(negedge clk);
      chk($sformatf("v%0d_mem", i), mem[vecs[i].adr[9:2]], vecs[i].exp_mem);
      chk($sformatf("v%0d_ecc", i), ecc[vecs[i].adr[9:2]], {25'b0, tb_enc(vecs[i].exp_mem)});
    end
    chk("clean_counts", {ce_cnt, ue_cnt}, 32'h0);

    // Single-bit error in data bit 5.
    mem[4] = 32'hDEADBEEF ^ 32'h20;
    do_txn(1'b0, 4'hF, 32'h10, 32'h0, lat, gerr, rd);
    chk("ce1_lat", lat, 4);
    chk("ce1_rdat", rd, 32'hDEADBEEF);
    chk("ce1_ce", ce_cnt, 32'h1);
    @(negedge clk);
`ifdef EDC_SCRUB_EN
    chk("ce1_scrub_mem", mem[4], 32'hDEADBEEF);
    chk("ce1_scrub_ecc", ecc[4], {25'b0, tb_enc(32'hDEADBEEF)});
    exp_ce = 32'h1;
`else
    chk("ce1_mem_kept", mem[4], 32'hDEADBEEF ^ 32'h20);
    exp_ce = 32'h2;
`endif
    do_txn(1'b0, 4'hF, 32'h10, 32'h0, lat, gerr, rd);
    chk("ce2_rdat", rd, 32'hDEADBEEF);
    chk("ce2_ce", ce_cnt, exp_ce);
    chk("ce2_ue", ue_cnt, 32'h0);

    // Double-bit error (bits 3 and 17).
    mem[4] = 32'hDEADBEEF ^ 32'h8 ^ 32'h20000;
    ecc[4] = {25'b0, tb_enc(32'hDEADBEEF)};
    wr0 = wr_cnt;
    do_txn(1'b0, 4'hF, 32'h10, 32'h0, lat, gerr, rd);
    chk("ue_lat", lat, 4);
    chk("ue_err", {31'b0, gerr}, 32'h1);
    chk("ue_ack_low", {31'b0, wb_ack}, 32'h0);
    chk("ue_rdat", rd, 32'h0);
    chk("ue_cnt", ue_cnt, 32'h1);
    chk("ue_ce_unchanged", ce_cnt, exp_ce);
    @(negedge clk);
    chk("ue_no_write", wr_cnt, wr0);
    chk("ue_mem_kept", mem[4], 32'hDEADBEEF ^ 32'h8 ^ 32'h20000);

    // Reset in the CHK cycle of a partial write.
    wr0 = wr_cnt;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'h1; wb_adr = 32'h20; wb_dat_w = 32'hEE;
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outs_zero", {31'b0, ({wb_dat_r, wb_ack, wb_err, mem_en, mem_we, mem_adr, mem_dat_w,
                                   ecc_dat_w, edcc_main, edcc_ecc, ce_cnt, ue_cnt} == '0)}, 32'h1);
    seen = 1'b0;
    repeat (8) begin
      if (wb_ack || wb_err) seen = 1'b1;
      @(negedge clk);
    end
    chk("rst_no_resp", {31'b0, seen}, 32'h0);
    chk("rst_no_write", wr_cnt, wr0);
    chk("rst_mem_kept", mem[8], 32'h1122AB44);
    do_txn(1'b0, 4'hF, 32'h20, 32'h0, lat, gerr, rd);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_rdat", rd, 32'h1122AB44);

    // Counter saturation: 15 CEs reach all ones, a 16th keeps it there.
    for (int i = 0; i < 16; i++) begin
      mem[4] = 32'hDEADBEEF ^ 32'h20;
      ecc[4] = {25'b0, tb_enc(32'hDEADBEEF)};
      do_txn(1'b0, 4'hF, 32'h10, 32'h0, lat, gerr, rd);
      if (i == 14) chk("sat_reach", ce_cnt, 32'hF);
    end
    chk("sat_hold", ce_cnt, 32'hF);
    chk("sat_rdat", rd, 32'hDEADBEEF);
    chk("sat_ue", ue_cnt, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
